// File: rtl/calc_entry_ctrl.sv
// Keystroke sequencer for the calculator datapath: builds signed decimal operands,
// holds the pending operator, runs one execute cycle and latches result or error.
module calc_entry_ctrl #(
    parameter int NB         = 48,
    parameter int MAX_DIGITS = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [4:0]    key_code,
    output logic          key_ready,
    output logic [NB-1:0] calc_a,
    output logic [NB-1:0] calc_b,
    output logic [2:0]    calc_op,
    input  logic [NB-1:0] calc_result,
    output logic [NB-1:0] disp_value,
    output logic          disp_err
);

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTRY_B = 3'd2,
        EXEC    = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } state_t;

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);

    function automatic logic signed [NB-1:0] range_lim();
        logic signed [NB-1:0] v;
        v = 1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            v = v * $signed(NB'(10));
        end
        return v - 1;
    endfunction

    localparam logic signed [NB-1:0] POS_LIM = range_lim();
    localparam logic signed [NB-1:0] NEG_LIM = -POS_LIM;

    // x10 via shift-add at NB+4 bits; dig_cnt keeps the true value inside NB bits.
    function automatic logic [NB-1:0] mul10(input logic [NB-1:0] v);
        logic [NB+3:0] ext;
        ext = {{4{v[NB-1]}}, v};
        ext = (ext << 3) + (ext << 1);
        return ext[NB-1:0];
    endfunction

    state_t        state_q, state_d;
    logic [NB-1:0] acc_a_q, acc_a_d;
    logic [NB-1:0] acc_b_q, acc_b_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    next_op_q, next_op_d;
    logic          chain_q, chain_d;
    logic [DW-1:0] dig_cnt_q, dig_cnt_d;
    logic          neg_q, neg_d;
    logic [NB-1:0] calc_a_q, calc_a_d;
    logic [NB-1:0] calc_b_q, calc_b_d;
    logic [2:0]    calc_op_q, calc_op_d;
    logic [NB-1:0] disp_value_q, disp_value_d;
    logic          disp_err_q, disp_err_d;

    logic          key_acc;
    logic          is_digit, is_op, is_eq, is_clr, is_neg;
    logic [4:0]    op_sub;
    logic [2:0]    op_code;
    logic [NB-1:0] d_ext;
    logic          d_nonzero;
    logic          digit_ok;
    logic [NB-1:0] ent_a, ent_b;
    logic          exec_err;

    assign key_ready  = ~rst && (state_q != EXEC);
    assign key_acc    = key_valid && key_ready;

    assign is_digit   = (key_code <= 5'd9);
    assign is_op      = (key_code >= 5'd10) && (key_code <= 5'd14);
    assign is_eq      = (key_code == 5'd15);
    assign is_clr     = (key_code == 5'd16);
    assign is_neg     = (key_code == 5'd17);
    assign op_sub     = key_code - 5'd10;
    assign op_code    = op_sub[2:0];
    assign d_ext      = {{(NB-4){1'b0}}, key_code[3:0]};
    assign d_nonzero  = (key_code[3:0] != 4'd0);
    assign digit_ok   = (dig_cnt_q < DIG_MAX);

    assign ent_a = neg_q ? (mul10(acc_a_q) - d_ext) : (mul10(acc_a_q) + d_ext);
    assign ent_b = neg_q ? (mul10(acc_b_q) - d_ext) : (mul10(acc_b_q) + d_ext);

    // Divide-by-zero and negative exponent are decided before the result is looked at.
    always_comb begin
        exec_err = 1'b0;
        if (op_q == 3'd3 && acc_b_q == '0) begin
            exec_err = 1'b1;
        end else if (op_q == 3'd4 && acc_b_q[NB-1]) begin
            exec_err = 1'b1;
        end else if ($signed(calc_result) > POS_LIM || $signed(calc_result) < NEG_LIM) begin
            exec_err = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_a_d      = acc_a_q;
        acc_b_d      = acc_b_q;
        op_d         = op_q;
        next_op_d    = next_op_q;
        chain_d      = chain_q;
        dig_cnt_d    = dig_cnt_q;
        neg_d        = neg_q;
        calc_a_d     = calc_a_q;
        calc_b_d     = calc_b_q;
        calc_op_d    = calc_op_q;
        disp_value_d = disp_value_q;
        disp_err_d   = disp_err_q;

        case (state_q)
            ENTRY_A: begin
                if (key_acc) begin
                    if (is_digit) begin
                        if (digit_ok) begin
                            acc_a_d = ent_a;
                            if (acc_a_q != '0 || d_nonzero) dig_cnt_d = dig_cnt_q + 1'b1;
                        end
                    end else if (is_neg) begin
                        neg_d   = ~neg_q;
                        acc_a_d = -acc_a_q;
                    end else if (is_op) begin
                        op_d      = op_code;
                        neg_d     = 1'b0;
                        dig_cnt_d = '0;
                        state_d   = OP_WAIT;
                    end
                end
            end
            OP_WAIT: begin
                if (key_acc) begin
                    if (is_digit) begin
                        acc_b_d   = d_ext;
                        neg_d     = 1'b0;
                        dig_cnt_d = DW'(d_nonzero);
                        state_d   = ENTRY_B;
                    end else if (is_neg) begin
                        acc_b_d   = '0;
                        neg_d     = 1'b1;
                        dig_cnt_d = '0;
                        state_d   = ENTRY_B;
                    end else if (is_op) begin
                        op_d = op_code;
                    end
                end
            end
            ENTRY_B: begin
                if (key_acc) begin
                    if (is_digit) begin
                        if (digit_ok) begin
                            acc_b_d = ent_b;
                            if (acc_b_q != '0 || d_nonzero) dig_cnt_d = dig_cnt_q + 1'b1;
                        end
                    end else if (is_neg) begin
                        neg_d   = ~neg_q;
                        acc_b_d = -acc_b_q;
                    end else if (is_op || is_eq) begin
                        chain_d   = is_op;
                        next_op_d = is_op ? op_code : next_op_q;
                        calc_a_d  = acc_a_q;
                        calc_b_d  = acc_b_q;
                        calc_op_d = op_q;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (exec_err) begin
                    disp_err_d = 1'b1;
                    state_d    = ERROR;
                end else begin
                    acc_a_d   = calc_result;
                    acc_b_d   = '0;
                    neg_d     = 1'b0;
                    dig_cnt_d = '0;
                    if (chain_q) begin
                        op_d    = next_op_q;
                        state_d = OP_WAIT;
                    end else begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (key_acc) begin
                    if (is_digit) begin
                        acc_a_d   = d_ext;
                        neg_d     = 1'b0;
                        dig_cnt_d = DW'(d_nonzero);
                        state_d   = ENTRY_A;
                    end else if (is_neg) begin
                        acc_a_d = -acc_a_q;
                    end else if (is_op) begin
                        op_d      = op_code;
                        neg_d     = 1'b0;
                        dig_cnt_d = '0;
                        state_d   = OP_WAIT;
                    end
                end
            end
            ERROR: begin
            end
            default: begin
                state_d = ENTRY_A;
            end
        endcase

        case (state_q)
            ENTRY_A, OP_WAIT, RESULT: disp_value_d = acc_a_q;
            ENTRY_B:                  disp_value_d = acc_b_q;
            ERROR:                    disp_value_d = '0;
            default:                  disp_value_d = disp_value_q;
        endcase

        // key_ready is low in EXEC, so clear can never abort an execute.
        if (key_acc && is_clr) begin
            state_d      = ENTRY_A;
            acc_a_d      = '0;
            acc_b_d      = '0;
            op_d         = '0;
            next_op_d    = '0;
            chain_d      = 1'b0;
            dig_cnt_d    = '0;
            neg_d        = 1'b0;
            disp_value_d = '0;
            disp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ENTRY_A;
            acc_a_q      <= '0;
            acc_b_q      <= '0;
            op_q         <= '0;
            next_op_q    <= '0;
            chain_q      <= 1'b0;
            dig_cnt_q    <= '0;
            neg_q        <= 1'b0;
            calc_a_q     <= '0;
            calc_b_q     <= '0;
            calc_op_q    <= '0;
            disp_value_q <= '0;
            disp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_a_q      <= acc_a_d;
            acc_b_q      <= acc_b_d;
            op_q         <= op_d;
            next_op_q    <= next_op_d;
            chain_q      <= chain_d;
            dig_cnt_q    <= dig_cnt_d;
            neg_q        <= neg_d;
            calc_a_q     <= calc_a_d;
            calc_b_q     <= calc_b_d;
            calc_op_q    <= calc_op_d;
            disp_value_q <= disp_value_d;
            disp_err_q   <= disp_err_d;
        end
    end

    assign calc_a     = calc_a_q;
    assign calc_b     = calc_b_q;
    assign calc_op    = calc_op_q;
    assign disp_value = disp_value_q;
    assign disp_err   = disp_err_q;

endmodule
